// File: rtl/sdram_pkg.sv
// Shared command codes, sequencer state encoding and a constant clog2 helper
// for the SDRAM access sequencer slice.
package sdram_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_PRE    = 4'd1,
    ST_TRP_W  = 4'd2,
    ST_ACT    = 4'd3,
    ST_TRCD_W = 4'd4,
    ST_COL    = 4'd5,
    ST_RPRE   = 4'd6,
    ST_RTRP_W = 4'd7,
    ST_REF    = 4'd8,
    ST_TRFC_W = 4'd9
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sdram_wait_counter.sv
// Loadable down-counter shared by the tRP, tRCD and tRFC waits; holds at zero.
module sdram_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - WIDTH'(1);
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sdram_access_sequencer.sv
// Sequences one SDRAM access (hit: RD/WR; miss: PRE, ACT, RD/WR) or a full
// refresh (PRE to every bank, then REF), driving the bank tracker pulses.
//
// state   | meaning
// IDLE    | arbitrate: refresh first, then access request
// PRE     | precharge the requested bank
// TRP_W   | wait out tRP before ACT
// ACT     | open the requested row
// TRCD_W  | wait out tRCD before the column command
// COL     | RD/WR, request consumed
// RPRE    | precharge banks 0..N-1, one per cycle
// RTRP_W  | wait out tRP before REF
// REF     | issue refresh
// TRFC_W  | wait out tRFC, ack on the last cycle
module sdram_access_sequencer
  import sdram_pkg::*;
#(
  parameter int ROW_BITS  = 13,
  parameter int BANK_BITS = 2,
  parameter int COL_BITS  = 10,
  parameter int T_RP      = 3,
  parameter int T_RCD     = 3,
  parameter int T_RFC     = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [BANK_BITS-1:0] req_bank,
  input  logic [ROW_BITS-1:0]  req_row,
  input  logic [COL_BITS-1:0]  req_col,
  input  logic                 ref_req,
  output logic                 ref_ack,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [BANK_BITS-1:0] cmd_bank,
  output logic [ROW_BITS-1:0]  cmd_addr,
  output logic [BANK_BITS-1:0] query_bank,
  output logic [ROW_BITS-1:0]  query_row,
  input  logic                 row_hit,
  output logic                 set_active_pulse,
  output logic [BANK_BITS-1:0] set_bank,
  output logic [ROW_BITS-1:0]  set_row,
  output logic                 clear_active_pulse,
  output logic [BANK_BITS-1:0] clear_bank
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int T_MAX = (T_RP > T_RCD) ? ((T_RP > T_RFC) ? T_RP : T_RFC)
                                        : ((T_RCD > T_RFC) ? T_RCD : T_RFC);
  localparam int CNT_W = (clog2(T_MAX + 1) < 1) ? 1 : clog2(T_MAX + 1);

  // Load values count the wait-state cycles still to go after the first one;
  // T=1 bypasses the wait state entirely.
  localparam logic [CNT_W-1:0] LD_RP  = (T_RP  > 1) ? CNT_W'(T_RP - 2)  : '0;
  localparam logic [CNT_W-1:0] LD_RCD = (T_RCD > 1) ? CNT_W'(T_RCD - 2) : '0;
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
  localparam logic [BANK_BITS-1:0] LAST_BANK = BANK_BITS'(NUM_BANKS - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 r_we;
  logic [BANK_BITS-1:0] r_bank;
  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;
  logic                 w_load;
  logic [CNT_W-1:0]     w_load_val;
  logic                 w_done;

  assign query_bank = req_bank;
  assign query_row  = req_row;

  sdram_wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_bank  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        if (ref_req) begin
          r_bank <= '0;
        end else if (req_valid) begin
          r_we   <= req_we;
          r_bank <= req_bank;
          r_row  <= req_row;
          r_col  <= req_col;
        end
      end else if (r_state == ST_RPRE && r_bank != LAST_BANK) begin
        r_bank <= r_bank + BANK_BITS'(1);
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (ref_req)        w_next = ST_RPRE;
        else if (req_valid) w_next = row_hit ? ST_COL : ST_PRE;
      end
      ST_PRE: begin
        if (T_RP > 1) begin
          w_next     = ST_TRP_W;
          w_load     = 1'b1;
          w_load_val = LD_RP;
        end else begin
          w_next = ST_ACT;
        end
      end
      ST_TRP_W:  if (w_done) w_next = ST_ACT;
      ST_ACT: begin
        if (T_RCD > 1) begin
          w_next     = ST_TRCD_W;
          w_load     = 1'b1;
          w_load_val = LD_RCD;
        end else begin
          w_next = ST_COL;
        end
      end
      ST_TRCD_W: if (w_done) w_next = ST_COL;
      ST_COL:    w_next = ST_IDLE;
      ST_RPRE: begin
        if (r_bank == LAST_BANK) begin
          if (T_RP > 1) begin
            w_next     = ST_RTRP_W;
            w_load     = 1'b1;
            w_load_val = LD_RP;
          end else begin
            w_next = ST_REF;
          end
        end
      end
      ST_RTRP_W: if (w_done) w_next = ST_REF;
      ST_REF: begin
        w_next     = ST_TRFC_W;
        w_load     = 1'b1;
        w_load_val = LD_RFC;
      end
      ST_TRFC_W: if (w_done) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready          = 1'b0;
    ref_ack            = 1'b0;
    cmd_valid          = 1'b0;
    cmd_code           = CMD_NOP;
    cmd_bank           = '0;
    cmd_addr           = '0;
    set_active_pulse   = 1'b0;
    set_bank           = '0;
    set_row            = '0;
    clear_active_pulse = 1'b0;
    clear_bank         = '0;
    case (r_state)
      ST_PRE, ST_RPRE: begin
        cmd_valid          = 1'b1;
        cmd_code           = CMD_PRE;
        cmd_bank           = r_bank;
        clear_active_pulse = 1'b1;
        clear_bank         = r_bank;
      end
      ST_ACT: begin
        cmd_valid        = 1'b1;
        cmd_code         = CMD_ACT;
        cmd_bank         = r_bank;
        cmd_addr         = r_row;
        set_active_pulse = 1'b1;
        set_bank         = r_bank;
        set_row          = r_row;
      end
      ST_COL: begin
        cmd_valid = 1'b1;
        cmd_code  = r_we ? CMD_WR : CMD_RD;
        cmd_bank  = r_bank;
        cmd_addr  = ROW_BITS'(r_col);
        req_ready = 1'b1;
      end
      ST_REF: begin
        cmd_valid = 1'b1;
        cmd_code  = CMD_REF;
      end
      ST_TRFC_W: ref_ack = w_done;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_access_sequencer.sv
// Directed scoreboard bench: expected commands are queued when stimulus is
// driven and checked field-by-field (including issue cycle) as the DUT emits them.
module tb_sdram_access_sequencer;

  localparam int T_RP  = 3;
  localparam int T_RCD = 3;
  localparam int T_RFC = 9;
  localparam int NB    = 4;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_ACT = 3'd1;
  localparam logic [2:0] C_RD  = 3'd2;
  localparam logic [2:0] C_WR  = 3'd3;
  localparam logic [2:0] C_PRE = 3'd4;
  localparam logic [2:0] C_REF = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, ref_req, row_hit;
  logic [1:0]  req_bank;
  logic [12:0] req_row;
  logic [9:0]  req_col;
  logic        req_ready, ref_ack, cmd_valid;
  logic [2:0]  cmd_code;
  logic [1:0]  cmd_bank, query_bank, set_bank, clear_bank;
  logic [12:0] cmd_addr, query_row, set_row;
  logic        set_active_pulse, clear_active_pulse;

  sdram_access_sequencer #(
    .ROW_BITS(13), .BANK_BITS(2), .COL_BITS(10),
    .T_RP(T_RP), .T_RCD(T_RCD), .T_RFC(T_RFC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
    .query_bank(query_bank), .query_row(query_row), .row_hit(row_hit),
    .set_active_pulse(set_active_pulse), .set_bank(set_bank), .set_row(set_row),
    .clear_active_pulse(clear_active_pulse), .clear_bank(clear_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        v;
    logic [2:0]  code;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        rdy;
    logic        set;
    logic        clr;
    logic        ack;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic void push(int c, logic v, logic [2:0] code, logic [1:0] b,
                               logic [12:0] a, logic rdy, logic s, logic cl, logic ack);
    exp_t e;
    e.cyc = c; e.v = v; e.code = code; e.bank = b; e.addr = a;
    e.rdy = rdy; e.set = s; e.clr = cl; e.ack = ack;
    q.push_back(e);
  endfunction

  task automatic push_access(int c0, logic we, logic [1:0] b, logic [12:0] row,
                             logic [9:0] col, logic hit);
    logic [2:0] cc;
    cc = we ? C_WR : C_RD;
    if (hit) begin
      push(c0 + 1, 1, cc, b, {3'b000, col}, 1, 0, 0, 0);
    end else begin
      push(c0 + 1, 1, C_PRE, b, 13'd0, 0, 0, 1, 0);
      push(c0 + 1 + T_RP, 1, C_ACT, b, row, 0, 1, 0, 0);
      push(c0 + 1 + T_RP + T_RCD, 1, cc, b, {3'b000, col}, 1, 0, 0, 0);
    end
  endtask

  task automatic push_refresh(int c0);
    int r;
    for (int i = 0; i < NB; i++) push(c0 + 1 + i, 1, C_PRE, 2'(i), 13'd0, 0, 0, 1, 0);
    r = c0 + NB + T_RP;
    push(r, 1, C_REF, 2'd0, 13'd0, 0, 0, 0, 0);
    push(r + T_RFC, 0, C_NOP, 2'd0, 13'd0, 0, 0, 0, 1);
  endtask

  task automatic drive_req(logic we, logic [1:0] b, logic [12:0] row, logic [9:0] col, logic hit);
    req_valid = 1'b1; req_we = we; req_bank = b; req_row = row; req_col = col; row_hit = hit;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    chk(tag, 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    row_hit   = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ref_ack) break;
    end
    chk(tag, 32'(ref_ack), 32'd1);
    ref_req = 1'b0;
  endtask

  task automatic access(logic we, logic [1:0] b, logic [12:0] row, logic [9:0] col,
                        logic hit, input string tag);
    @(negedge clk);
    drive_req(we, b, row, col, hit);
    push_access(cyc, we, b, row, col, hit);
    #1;
    chk({tag, "_query_bank"}, 32'(query_bank), 32'(b));
    chk({tag, "_query_row"}, 32'(query_row), 32'(row));
    wait_ready({tag, "_ready"});
  endtask

  always @(negedge clk) begin
    if (mon_en && (cmd_valid || ref_ack || req_ready || set_active_pulse || clear_active_pulse)) begin
      if (q.size() == 0) begin
        chk("unexpected_cmd_code", 32'(cmd_code), 32'(C_NOP));
        chk("unexpected_activity", 32'({cmd_valid, ref_ack, req_ready, set_active_pulse, clear_active_pulse}), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cycle", 32'(cyc), 32'(e.cyc));
        chk("cmd_valid", 32'(cmd_valid), 32'(e.v));
        chk("cmd_code", 32'(cmd_code), 32'(e.code));
        chk("cmd_bank", 32'(cmd_bank), 32'(e.v ? e.bank : 2'd0));
        chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
        chk("req_ready", 32'(req_ready), 32'(e.rdy));
        chk("set_pulse", 32'(set_active_pulse), 32'(e.set));
        chk("set_bank", 32'(set_bank), 32'(e.set ? e.bank : 2'd0));
        chk("set_row", 32'(set_row), 32'(e.set ? e.addr : 13'd0));
        chk("clear_pulse", 32'(clear_active_pulse), 32'(e.clr));
        chk("clear_bank", 32'(clear_bank), 32'(e.clr ? e.bank : 2'd0));
        chk("ref_ack", 32'(ref_ack), 32'(e.ack));
      end
    end
  end

  initial begin
    int c0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bank = '0; req_row = '0;
    req_col = '0; ref_req = 1'b0; row_hit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_code", 32'(cmd_code), 32'(C_NOP));
    chk("rst_fields", 32'({cmd_bank, cmd_addr, set_bank, set_row, clear_bank}), 32'd0);
    chk("rst_pulses", 32'({req_ready, ref_ack, set_active_pulse, clear_active_pulse}), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    access(1'b0, 2'd2, 13'h0AA, 10'h015, 1'b1, "hit_rd_b2");
    access(1'b1, 2'd1, 13'h123, 10'h007, 1'b0, "miss_wr_b1");
    access(1'b1, 2'd0, 13'h000, 10'h3FF, 1'b1, "hit_wr_maxcol");
    access(1'b0, 2'd3, 13'h1FFF, 10'h000, 1'b0, "miss_rd_maxrow");

    @(negedge clk);
    ref_req = 1'b1;
    push_refresh(cyc);
    wait_ack("refresh_ack");

    // Refresh and request together: refresh wins, request issues right after ack.
    @(negedge clk);
    c0 = cyc;
    ref_req = 1'b1;
    drive_req(1'b0, 2'd3, 13'h055, 10'h2A0, 1'b1);
    push_refresh(c0);
    push_access(c0 + NB + T_RP + T_RFC + 1, 1'b0, 2'd3, 13'h055, 10'h2A0, 1'b1);
    wait_ack("both_ack");
    wait_ready("both_ready");

    // Reset while waiting out tRCD: no column command may follow.
    @(negedge clk);
    drive_req(1'b1, 2'd2, 13'h0F0, 10'h011, 1'b0);
    push_access(cyc, 1'b1, 2'd2, 13'h0F0, 10'h011, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (set_active_pulse) break;
    end
    chk("rst_mid_act_seen", 32'(set_active_pulse), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    row_hit = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_mid_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_mid_pulses", 32'({req_ready, set_active_pulse, clear_active_pulse}), 32'd0);
    rst_n = 1'b1;
    repeat (T_RCD + 4) @(negedge clk);
    access(1'b0, 2'd1, 13'h0F0, 10'h033, 1'b1, "post_rst_hit");
    access(1'b1, 2'd2, 13'h0F1, 10'h034, 1'b0, "post_rst_miss");

    repeat (6) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
